// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and memory arbiter FSM state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants that passed over a waiting fetch.
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clr,
  output logic sat_out
);

  localparam logic [STARVE_W-1:0] MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && cnt_q != MAX)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign sat_out = (cnt_q == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between fetch and data; data wins unless fetch starves.
// Define MEM_ARBITER_PERF_EN to add istall_cnt/dstall_cnt stall counters.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  ihit,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dhit,
  output word_t dload,
  input  logic  halt,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload,
  input  logic  ramready
`ifdef MEM_ARBITER_PERF_EN
  ,
  output word_t istall_cnt,
  output word_t dstall_cnt
`endif
);

  arb_state_t state_q;
  word_t      addr_q;
  word_t      data_q;
  logic       wr_q;

  logic dreq, ireq, idle, sat;
  logic grant_i, grant_d;
  logic cnt_inc, cnt_clr;

  assign dreq = dREN | dWEN;
  assign ireq = iREN & ~halt;
  assign idle = (state_q == IDLE);

  assign grant_i = idle & ireq & (~dreq | sat);
  assign grant_d = idle & dreq & ~grant_i;

  // Skipped fetches are counted against iREN, not ireq, so halt still ages it.
  assign cnt_inc = grant_d & iREN;
  assign cnt_clr = grant_i | (grant_d & ~iREN);

  arb_starve_ctr #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .sat_out(sat)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant_i) begin
            state_q <= IACC;
            addr_q  <= iaddr;
            wr_q    <= 1'b0;
          end else if (grant_d) begin
            state_q <= DACC;
            addr_q  <= daddr;
            data_q  <= dstore;
            wr_q    <= dWEN;
          end
        end
        IACC: if (ramready) state_q <= IDLE;
        DACC: if (ramready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic in_i, in_d;

  assign in_i = (state_q == IACC);
  assign in_d = (state_q == DACC);

  assign ramREN   = in_i | (in_d & ~wr_q);
  assign ramWEN   = in_d & wr_q;
  assign ramaddr  = (in_i | in_d) ? addr_q : '0;
  assign ramstore = in_d ? data_q : '0;

  assign ihit  = in_i & ramready;
  assign iload = ihit ? ramload : '0;
  assign dhit  = in_d & ramready;
  assign dload = (dhit & ~wr_q) ? ramload : '0;

`ifdef MEM_ARBITER_PERF_EN
  word_t istall_q, dstall_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      istall_q <= '0;
      dstall_q <= '0;
    end else begin
      if (iREN & ~ihit) istall_q <= istall_q + 1'b1;
      if (dreq & ~dhit) dstall_q <= dstall_q + 1'b1;
    end
  end

  assign istall_cnt = istall_q;
  assign dstall_cnt = dstall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cases plus random traffic.
module tb_mem_arbiter;

  localparam int SM = 4;

  logic        CLK, nRST;
  logic        iREN, dREN, dWEN, halt, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_PERF_EN
  logic [31:0] istall_cnt, dstall_cnt;
`endif

  mem_arbiter #(.STARVE_MAX(SM)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
`ifdef MEM_ARBITER_PERF_EN
    , .istall_cnt(istall_cnt), .dstall_cnt(dstall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit run_cmp = 0;

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: which access is in flight and what it latched.
  int          m_busy;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr, m_data;
  bit          m_wr;
  int          m_skip;   // data grants that jumped a waiting fetch
  logic [31:0] m_ist, m_dst;

  always @(posedge CLK or negedge nRST) begin
    bit dq, iq;
    if (!nRST) begin
      m_busy = 0; m_addr = 0; m_data = 0; m_wr = 0;
      m_skip = 0; m_ist = 0; m_dst = 0;
    end else begin
      if (iREN && !(m_busy == 1 && ramready)) m_ist = m_ist + 1;
      if ((dREN || dWEN) && !(m_busy == 2 && ramready)) m_dst = m_dst + 1;
      if (m_busy == 0) begin
        dq = dREN || dWEN;
        iq = iREN && !halt;
        if (iq && (!dq || m_skip == SM)) begin
          m_busy = 1; m_addr = iaddr; m_skip = 0;
        end else if (dq) begin
          m_busy = 2; m_addr = daddr; m_data = dstore; m_wr = dWEN;
          m_skip = iREN ? ((m_skip < SM) ? m_skip + 1 : SM) : 0;
        end
      end else if (ramready) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST && run_cmp) begin
      chk1("ramREN", ramREN, m_busy == 1 || (m_busy == 2 && !m_wr));
      chk1("ramWEN", ramWEN, m_busy == 2 && m_wr);
      chk1("ihit", ihit, m_busy == 1 && ramready);
      chk1("dhit", dhit, m_busy == 2 && ramready);
      if (m_busy != 0) chk32("ramaddr", ramaddr, m_addr);
      if (m_busy == 2) chk32("ramstore", ramstore, m_data);
      if (m_busy == 1 && ramready) chk32("iload", iload, ramload);
      if (m_busy == 2 && ramready)
        chk32("dload", dload, m_wr ? 32'h0 : ramload);
`ifdef MEM_ARBITER_PERF_EN
      chk32("istall_cnt", istall_cnt, m_ist);
      chk32("dstall_cnt", dstall_cnt, m_dst);
`endif
    end
  end

  task automatic drv();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic drain();
    iREN = 0; dREN = 0; dWEN = 0; halt = 0; ramready = 1;
    repeat (3) drv();
  endtask

  int hseq[$];

  // Records hit order (1 = data, 2 = fetch) over n sampled cycles.
  task automatic collect(input int n);
    hseq.delete();
    for (int k = 0; k < n; k++) begin
      smp();
      if (dhit) hseq.push_back(1);
      if (ihit) hseq.push_back(2);
    end
  endtask

  task automatic chk_pattern(input string nm, input int n);
    chk32({nm, "_len"}, hseq.size(), n);
    for (int i = 0; i < hseq.size() && i < n; i++)
      chk32(nm, hseq[i], (i % 5 == 4) ? 2 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ih, dh;
    bit ih_s, dh_s;
    int kind;
    nRST = 0; iREN = 0; dREN = 0; dWEN = 0; halt = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;

    #3;
    chk1("rst_ihit", ihit, 1'b0);
    chk1("rst_dhit", dhit, 1'b0);
    chk1("rst_ramREN", ramREN, 1'b0);
    chk1("rst_ramWEN", ramWEN, 1'b0);
    chk32("rst_ramaddr", ramaddr, 32'h0);
    chk32("rst_ramstore", ramstore, 32'h0);
    chk32("rst_iload", iload, 32'h0);
    chk32("rst_dload", dload, 32'h0);
    @(negedge CLK);
    nRST = 1;
    run_cmp = 1;

    // fetch only, RAM ready on second access cycle
    drv(); iREN = 1; iaddr = 32'h40; ramready = 0;
    drv();
    smp();
    chk1("f_ren1", ramREN, 1'b1);
    chk1("f_nohit", ihit, 1'b0);
    chk32("f_addr1", ramaddr, 32'h40);
    drv(); ramready = 1; ramload = 32'h8C220004; iaddr = 32'h999;
    smp();
    chk1("f_ihit", ihit, 1'b1);
    chk32("f_iload", iload, 32'h8C220004);
    chk1("f_ren2", ramREN, 1'b1);
    chk1("f_wen", ramWEN, 1'b0);
    chk32("f_addr2", ramaddr, 32'h40);
    drv(); iREN = 0; ramready = 0;
    smp();
    chk1("f_idle_ren", ramREN, 1'b0);
    chk1("f_idle_hit", ihit, 1'b0);

    // simultaneous: data first, fetch two cycles later
    drv();
    iREN = 1; iaddr = 32'h44; dREN = 1; daddr = 32'h100;
    ramready = 1; ramload = 32'h11111111;
    smp();
    drv();
    smp();
    chk1("s_dhit1", dhit, 1'b1);
    chk1("s_ihit1", ihit, 1'b0);
    chk32("s_addr1", ramaddr, 32'h100);
    chk32("s_dload", dload, 32'h11111111);
    drv(); dREN = 0;
    smp();
    chk1("s_gap_i", ihit, 1'b0);
    chk1("s_gap_d", dhit, 1'b0);
    drv();
    smp();
    chk1("s_ihit3", ihit, 1'b1);
    chk32("s_addr3", ramaddr, 32'h44);
    drv(); iREN = 0;

    // starvation bound: four data hits then one fetch, repeating
    drv();
    iREN = 1; dREN = 1; ramready = 1; iaddr = 32'h60; daddr = 32'h120;
    collect(20);
    chk_pattern("starve", 10);
    drain();

    // write latches address and data at grant
    iREN = 0; dWEN = 1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    ramready = 0;
    drv(); daddr = 0; dstore = 0; ramready = 1; ramload = 32'h12345678;
    smp();
    chk1("w_wen", ramWEN, 1'b1);
    chk1("w_ren", ramREN, 1'b0);
    chk32("w_addr", ramaddr, 32'h200);
    chk32("w_store", ramstore, 32'hDEADBEEF);
    chk1("w_dhit", dhit, 1'b1);
    chk32("w_dload", dload, 32'h0);
    drain();

    // async reset in the middle of a write
    iREN = 1; dWEN = 1; daddr = 32'h500; dstore = 32'hCAFE; ramready = 0;
    drv();
    #2;
    chk1("r_wen_before", ramWEN, 1'b1);
    nRST = 0;
    #1;
    chk1("r_wen_after", ramWEN, 1'b0);
    chk1("r_ren_after", ramREN, 1'b0);
    chk32("r_addr_after", ramaddr, 32'h0);
    iREN = 0; dWEN = 0;
    @(negedge CLK);
    #2;
    nRST = 1;
    drv();
    iREN = 1; dREN = 1; ramready = 1;
    collect(10);
    chk_pattern("post_rst", 5);
    drain();

    // halt: fetch in flight finishes, then only data is granted
    iREN = 1; iaddr = 32'hA00; ramready = 0;
    drv(); halt = 1; ramready = 1; ramload = 32'h13579BDF; daddr = 32'h300;
    smp();
    chk1("h_inflight", ihit, 1'b1);
    chk32("h_iload", iload, 32'h13579BDF);
    ih = 0; dh = 0;
    for (int k = 0; k < 16; k++) begin
      drv(); dREN = k[0];
      smp();
      if (ihit) ih++;
      if (dhit) dh++;
      if (ramREN) chk32("h_addr", ramaddr, 32'h300);
    end
    chk32("h_no_ihit", ih, 0);
    chk1("h_some_dhit", dh > 0, 1'b1);
    drain();

    // random traffic with requests held until hit
    ih_s = 0; dh_s = 0;
    for (int c = 0; c < 3000; c++) begin
      drv();
      if (!iREN || ih_s) iREN = ($urandom % 3) != 0;
      if (!(dREN || dWEN) || dh_s) begin
        kind = $urandom % 4;
        dREN = kind[0];
        dWEN = kind[1];
      end
      if ($urandom % 32 == 0) iREN = 0;
      if ($urandom % 32 == 0) begin dREN = 0; dWEN = 0; end
      if ($urandom % 16 == 0) halt = ~halt;
      ramready = $urandom % 2;
      ramload = $urandom;
      iaddr = $urandom;
      daddr = $urandom;
      dstore = $urandom;
      smp();
      ih_s = ihit;
      dh_s = dhit;
    end
    drain();
    run_cmp = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
